regfile_write_arbiter: RTL and testbench



---
 rtl/riscv_rf_pkg.sv | 16 +
 rtl/rr_arbiter2.sv | 37 +++
 rtl/regfile_write_arbiter.sv | 113 +++++++++++
 tb/tb_regfile_write_arbiter.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_rf_pkg.sv
// Shared register-file constants and the write-port bundle type used by
// the writeback arbiter.
package riscv_rf_pkg;

  localparam int XLEN       = 64;
  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** REG_ADDR_W;

  // One register-file write-port beat: enable, index and data.
  typedef struct packed {
    logic                  regWrite;
    logic [REG_ADDR_W-1:0] writeRegister;
    logic [XLEN-1:0]       writeData;
  } rfWrite_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin arbiter. The grant is combinational and
// one-hot. lastGrant remembers which port won the most recent accepted
// grant, so on a tie the other port wins. It resets to 1, which means
// port 0 wins the first tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic lastGrant;

  // Combinational one-hot grant. No grant is issued while reset is held.
  always_comb begin
    gnt = 2'b00;
    if (!rst) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = lastGrant ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  // Round-robin pointer. It moves only when the grant is actually consumed.
  always_ff @(posedge clk) begin
    if (rst) begin
      lastGrant <= 1'b1;
    end else if (advance && (gnt != 2'b00)) begin
      lastGrant <= gnt[1];
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file's single write port between the execute-stage
// writeback (port 0) and the load/multi-cycle writeback (port 1). It also
// keeps the busy scoreboard that issue logic uses for RAW/WAW stalls.
//
// Handshake: a transfer on port n happens in any cycle where
// reqn_valid && reqn_ready. A requester raises valid independently of
// ready, and it holds valid, rd and data stable until the transfer. Ready
// is a combinational grant: at most one port is ready per cycle, and
// neither port is ready while rst is high.
module regfile_write_arbiter
  import riscv_rf_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0_valid,
  input  logic [REG_ADDR_W-1:0] req0_rd,
  input  logic [XLEN-1:0]       req0_data,
  output logic                  req0_ready,
  input  logic                  req1_valid,
  input  logic [REG_ADDR_W-1:0] req1_rd,
  input  logic [XLEN-1:0]       req1_data,
  output logic                  req1_ready,
  input  logic                  rsv_valid,
  input  logic [REG_ADDR_W-1:0] rsv_rd,
  output logic                  rsv_conflict,
  output logic                  rf_regWrite,
  output logic [REG_ADDR_W-1:0] rf_writeRegister,
  output logic [XLEN-1:0]       rf_writeData,
  output logic [NUM_REGS-1:0]   busy
);

  logic [1:0]            gnt;
  logic                  transfer;
  logic [REG_ADDR_W-1:0] selRd;
  logic [XLEN-1:0]       selData;
  logic                  rsvAccept;
  logic [NUM_REGS-1:0]   busyReg;
  logic [NUM_REGS-1:0]   busyNext;
  rfWrite_t              wrPort;

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     ({req1_valid, req0_valid}),
    .advance (transfer),
    .gnt     (gnt)
  );

  assign req0_ready = gnt[0];
  assign req1_ready = gnt[1];
  // A grant is always taken in the same cycle because ready == grant
  // and grant implies valid.
  assign transfer   = gnt[0] | gnt[1];

  // Select the winning requester's destination and data.
  always_comb begin
    selRd   = req0_rd;
    selData = req0_data;
    if (gnt[1]) begin
      selRd   = req1_rd;
      selData = req1_data;
    end
  end

  // WAW check uses the busy value before this cycle's update, so a
  // same-cycle completing write to the same register still refuses the
  // reservation. Issue retries on the next cycle.
  assign rsv_conflict = rsv_valid & busyReg[rsv_rd];
  assign rsvAccept    = rsv_valid & ~rsv_conflict & (rsv_rd != '0);

  // Scoreboard next state. The clear from a completing write is applied
  // first and then an accepted reservation sets its register. x0 is
  // never tracked.
  always_comb begin
    busyNext = busyReg;
    if (transfer && (selRd != '0)) begin
      busyNext[selRd] = 1'b0;
    end
    if (rsvAccept) begin
      busyNext[rsv_rd] = 1'b1;
    end
    busyNext[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busyReg <= '0;
    end else begin
      busyReg <= busyNext;
    end
  end

  // Registered write port. The enable lasts one cycle per transfer and is
  // suppressed for x0. Index and data hold between writes.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPort <= '0;
    end else if (transfer) begin
      wrPort.regWrite      <= (selRd != '0);
      wrPort.writeRegister <= selRd;
      wrPort.writeData     <= selData;
    end else begin
      wrPort.regWrite <= 1'b0;
    end
  end

  assign rf_regWrite      = wrPort.regWrite;
  assign rf_writeRegister = wrPort.writeRegister;
  assign rf_writeData     = wrPort.writeData;
  assign busy             = busyReg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios plus random traffic,
// checked every cycle against a behavioural model of the arbitration,
// the write port and the scoreboard.
module tb_regfile_write_arbiter;

  localparam int XLEN = 64;
  localparam int RW   = 5;
  localparam int NR   = 32;
  localparam int W    = 1 + RW + XLEN;

  logic            clk;
  logic            rst;
  logic            req0_valid;
  logic [RW-1:0]   req0_rd;
  logic [XLEN-1:0] req0_data;
  logic            req0_ready;
  logic            req1_valid;
  logic [RW-1:0]   req1_rd;
  logic [XLEN-1:0] req1_data;
  logic            req1_ready;
  logic            rsv_valid;
  logic [RW-1:0]   rsv_rd;
  logic            rsv_conflict;
  logic            rf_regWrite;
  logic [RW-1:0]   rf_writeRegister;
  logic [XLEN-1:0] rf_writeData;
  logic [NR-1:0]   busy;

  regfile_write_arbiter dut (
    .clk              (clk),
    .rst              (rst),
    .req0_valid       (req0_valid),
    .req0_rd          (req0_rd),
    .req0_data        (req0_data),
    .req0_ready       (req0_ready),
    .req1_valid       (req1_valid),
    .req1_rd          (req1_rd),
    .req1_data        (req1_data),
    .req1_ready       (req1_ready),
    .rsv_valid        (rsv_valid),
    .rsv_rd           (rsv_rd),
    .rsv_conflict     (rsv_conflict),
    .rf_regWrite      (rf_regWrite),
    .rf_writeRegister (rf_writeRegister),
    .rf_writeData     (rf_writeData),
    .busy             (busy)
  );

  // Clock and idle input levels.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural model state.
  int              lastWinner;
  bit              busyM [NR];
  logic [RW-1:0]   holdRd;
  logic [XLEN-1:0] holdData;
  logic [W-1:0]    exp_q [$];

  // Observations from the most recent cycle, used by directed checks.
  int   lastWin;
  logic obsR0;
  logic obsR1;
  logic obsCf;

  int errors;
  int checks;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Runs one clock cycle whose inputs have just been applied in the low
  // phase. It checks the combinational outputs, advances the model at the
  // edge, and then checks the registered outputs.
  task automatic step();
    int              win;
    logic [RW-1:0]   wrd;
    logic [XLEN-1:0] wdat;
    logic            expCf;
    logic [NR-1:0]   expBusy;
    logic [W-1:0]    item;
    #1;
    win = -1;
    if (!rst) begin
      if (req0_valid && req1_valid) win = (lastWinner == 1) ? 0 : 1;
      else if (req0_valid)          win = 0;
      else if (req1_valid)          win = 1;
    end
    expCf = rsv_valid && busyM[rsv_rd];
    check("req0_ready", 64'(req0_ready), 64'(win == 0));
    check("req1_ready", 64'(req1_ready), 64'(win == 1));
    check("rsv_conflict", 64'(rsv_conflict), 64'(expCf));
    lastWin = win;
    obsR0   = req0_ready;
    obsR1   = req1_ready;
    obsCf   = rsv_conflict;
    wrd     = (win == 1) ? req1_rd : req0_rd;
    wdat    = (win == 1) ? req1_data : req0_data;

    if (rst) begin
      lastWinner = 1;
      foreach (busyM[i]) busyM[i] = 1'b0;
      holdRd   = '0;
      holdData = '0;
      exp_q.push_back({1'b0, RW'(0), XLEN'(0)});
    end else begin
      if (win >= 0) begin
        lastWinner = win;
        holdRd     = wrd;
        holdData   = wdat;
        if (wrd != 0) busyM[wrd] = 1'b0;
      end
      if (rsv_valid && !expCf && rsv_rd != 0) busyM[rsv_rd] = 1'b1;
      exp_q.push_back({(win >= 0) && (wrd != 0), holdRd, holdData});
    end

    @(posedge clk);
    #1;
    item = exp_q.pop_front();
    expBusy = '0;
    for (int i = 1; i < NR; i++) expBusy[i] = busyM[i];
    check("rf_regWrite", 64'(rf_regWrite), 64'(item[W-1]));
    check("rf_writeRegister", 64'(rf_writeRegister), 64'(item[XLEN +: RW]));
    check("rf_writeData", rf_writeData, item[XLEN-1:0]);
    check("busy", 64'(busy), 64'(expBusy));
  endtask

  // Applies one cycle of inputs at the falling edge and runs it.
  task automatic drive(input bit v0, input logic [RW-1:0] rd0, input logic [XLEN-1:0] d0,
                       input bit v1, input logic [RW-1:0] rd1, input logic [XLEN-1:0] d1,
                       input bit rv, input logic [RW-1:0] rrd, input bit r);
    @(negedge clk);
    req0_valid = v0; req0_rd = rd0; req0_data = d0;
    req1_valid = v1; req1_rd = rd1; req1_data = d1;
    rsv_valid  = rv; rsv_rd  = rrd; rst       = r;
    step();
  endtask

  // Directed scenarios followed by random traffic, then the report.
  initial begin
    logic [RW-1:0]   expSeqRd [4];
    logic [XLEN-1:0] expSeqD  [4];
    bit              p0, p1;
    logic [RW-1:0]   r0rd, r1rd;
    logic [XLEN-1:0] r0d, r1d;
    errors = 0; checks = 0;
    lastWinner = 1;
    foreach (busyM[i]) busyM[i] = 1'b0;
    holdRd = '0; holdData = '0;
    rst = 1'b1;
    req0_valid = 0; req0_rd = '0; req0_data = '0;
    req1_valid = 0; req1_rd = '0; req1_data = '0;
    rsv_valid = 0; rsv_rd = '0;

    // Reset with both ports valid, then the contention sequence.
    drive(1, 5, 64'hA5, 1, 6, 64'hA6, 0, 0, 1);
    drive(1, 5, 64'hA5, 1, 6, 64'hA6, 0, 0, 1);
    check("reset_ready0", 64'(obsR0), 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    expSeqRd[0] = 5; expSeqRd[1] = 6; expSeqRd[2] = 5; expSeqRd[3] = 6;
    expSeqD[0] = 64'hA5; expSeqD[1] = 64'hA6; expSeqD[2] = 64'hA5; expSeqD[3] = 64'hA6;
    for (int c = 0; c < 4; c++) begin
      drive(1, 5, 64'hA5, 1, 6, 64'hA6, 0, 0, 0);
      check("contention_win", 64'(lastWin), 64'(c % 2));
      check("contention_rd", 64'(rf_writeRegister), 64'(expSeqRd[c]));
      check("contention_data", rf_writeData, expSeqD[c]);
      check("contention_we", 64'(rf_regWrite), 64'd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("idle_we", 64'(rf_regWrite), 64'd0);

    // Scoreboard set, WAW refusal, and clear.
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0);
    check("rsv7_busy", 64'(busy[7]), 64'd1);
    drive(0, 0, 0, 0, 0, 0, 1, 7, 0);
    check("rsv7_conflict", 64'(obsCf), 64'd1);
    drive(0, 0, 0, 1, 7, 64'hDEAD_BEEF, 0, 0, 0);
    check("clr7_busy", 64'(busy[7]), 64'd0);
    check("clr7_data", rf_writeData, 64'hDEAD_BEEF);

    // A reservation that races a completing write to the same register.
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0);
    drive(1, 9, 64'h99, 0, 0, 0, 1, 9, 0);
    check("race_conflict", 64'(obsCf), 64'd1);
    check("race_busy", 64'(busy[9]), 64'd0);
    drive(0, 0, 0, 0, 0, 0, 1, 9, 0);
    check("retry_busy", 64'(busy[9]), 64'd1);
    drive(0, 9, 64'h9A, 1, 9, 64'h9A, 0, 0, 0);

    // x0 is never reserved, and writes to it are accepted without effect.
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("x0_rsv_busy", 64'(busy), 64'd0);
    drive(1, 0, 64'h1234, 0, 0, 0, 0, 0, 0);
    check("x0_ready", 64'(obsR0), 64'd1);
    check("x0_we", 64'(rf_regWrite), 64'd0);

    // Reset while a request is pending. The request is written after reset.
    drive(0, 0, 0, 0, 0, 0, 1, 3, 0);
    drive(0, 0, 0, 1, 3, 64'h33, 0, 0, 1);
    check("midrst_we", 64'(rf_regWrite), 64'd0);
    check("midrst_busy", 64'(busy), 64'd0);
    drive(0, 0, 0, 1, 3, 64'h33, 0, 0, 0);
    check("midrst_ready1", 64'(obsR1), 64'd1);
    check("midrst_we_after", 64'(rf_regWrite), 64'd1);
    check("midrst_rd_after", 64'(rf_writeRegister), 64'd3);

    // Random traffic: requesters hold their request until accepted.
    p0 = 0; p1 = 0; r0rd = '0; r1rd = '0; r0d = '0; r1d = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 99) == 0);
      if (!p0 && $urandom_range(0, 2) != 0) begin
        p0 = 1; r0rd = RW'($urandom_range(0, 7)); r0d = {$urandom, $urandom};
      end
      if (!p1 && $urandom_range(0, 2) != 0) begin
        p1 = 1; r1rd = RW'($urandom_range(0, 7)); r1d = {$urandom, $urandom};
      end
      req0_valid = p0; req0_rd = r0rd; req0_data = r0d;
      req1_valid = p1; req1_rd = r1rd; req1_data = r1d;
      rsv_valid  = 1'($urandom_range(0, 1));
      rsv_rd     = RW'($urandom_range(0, 7));
      step();
      if (lastWin == 0) p0 = 0;
      if (lastWin == 1) p1 = 0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
